muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand width and the HI/LO width.
REQ-002 The block SHALL have parameter WIDTH, legal range 4..64.
REQ-003 The block SHALL have port CLK  in  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port RST  in  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port Start  in  1  request strobe, sampled only in IDLE.
REQ-006 The block SHALL have port Op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-007 The block SHALL have port Rdata1  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
REQ-008 The block SHALL have port Rdata2  in  WIDTH  rt operand (multiplier / divisor).
REQ-009 The block SHALL have port Busy  out  1  high while an iterative operation is in progress.
REQ-010 The block SHALL have port Done  out  1  one-cycle completion pulse.
REQ-011 The block SHALL have port DivZero  out  1  one-cycle pulse, coincident with Done, for a divide with Rdata2 == 0.
REQ-012 The block SHALL have port Hi  out  WIDTH  HI register (serves MFHI).
REQ-013 The block SHALL have port Lo  out  WIDTH  LO register (serves MFLO).

Function
REQ-014 The state machine SHALL have the states IDLE, MUL, DIV and FIX.
REQ-015 Start sampled in IDLE with Op 000/001 SHALL load the operands and enter MUL.
REQ-016 Start sampled in IDLE with Op 010/011 SHALL load the operands and enter DIV.
REQ-017 For signed ops, operand magnitudes and result signs SHALL be captured on the accept edge.
REQ-018 MUL SHALL run radix-2 shift-add for exactly WIDTH cycles and then go to FIX.
REQ-019 DIV SHALL run radix-2 restoring division for exactly WIDTH cycles and then go to FIX.
REQ-020 FIX SHALL apply the sign correction, write Hi/Lo, and return to IDLE; latency from the accept edge to the Hi/Lo update edge SHALL be WIDTH+1 cycles.
REQ-021 Busy SHALL be high in MUL, DIV and FIX, and low in IDLE.
REQ-022 Done SHALL be high for exactly the one cycle following the Hi/Lo update edge.
REQ-023 Hi/Lo SHALL hold their previous values for the whole operation (no partial results visible).
REQ-024 MULT/MULTU SHALL produce the full 2*WIDTH product, with {Hi,Lo} = product; MULT treats operands as two's complement.
REQ-025 DIV/DIVU SHALL produce Lo = quotient and Hi = remainder.
REQ-026 Signed division SHALL truncate toward zero, and the remainder sign SHALL equal the dividend sign.
REQ-027 Signed MIN / -1 SHALL produce Lo = MIN and Hi = 0, with no error flag.
REQ-028 Divide by zero SHALL skip iteration: the next edge writes Hi = Rdata1 and Lo = all-ones, Done and DivZero pulse in the following cycle, and Busy is never asserted.
REQ-029 MTHI/MTLO with Start in IDLE SHALL write Hi or Lo from Rdata1 on that edge, with no Busy and no Done.
REQ-030 Start while Busy SHALL be ignored, and operand changes while Busy SHALL have no effect.
REQ-031 Start with a reserved Op SHALL be ignored, with no state change.
REQ-032 Start in IDLE on the cycle that Done is high SHALL be accepted (back-to-back operation).

Reset
REQ-033 RST high at a rising edge SHALL force IDLE, with Hi = 0, Lo = 0, Busy = 0, Done = 0 and DivZero = 0, and SHALL clear the iteration counter and datapath registers.
REQ-034 RST SHALL take priority over Start and over any in-flight operation.
REQ-035 An operation aborted by reset SHALL produce no Done.

Configuration
REQ-036 Macro MULDIV_DIV_EN defined SHALL compile in the DIV state, the divider datapath and the DivZero logic, giving the full behaviour above.
REQ-037 Macro MULDIV_DIV_EN undefined SHALL remove the divide hardware, treat Op 010/011 as reserved (ignored), and tie DivZero to 0.

Verification
REQ-038 The bench SHALL cover MULT with WIDTH=32, Rdata1=0xFFFFFFFE (-2), Rdata2=0x00000003 -> after 33 cycles Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, with a single Done pulse.
REQ-039 The bench SHALL cover MULTU with 0xFFFFFFFF * 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, and Busy high for exactly 33 cycles.
REQ-040 The bench SHALL cover DIV with -7 / 2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1), and DIVU with 0x80000000 / 0xFFFFFFFF -> Lo=0, Hi=0x80000000.
REQ-041 The bench SHALL cover DIVU 5 / 0 -> on the next edge Hi=5 and Lo=0xFFFFFFFF, Done and DivZero high together for 1 cycle, and Busy never high.
REQ-042 The bench SHALL cover MTHI 0x12345678, then Start MULT at cycle 10 with RST at cycle 20 -> Hi=0 and Lo=0, IDLE, no Done; a second Start while Busy is ignored.
REQ-043 The bench SHALL build without MULDIV_DIV_EN and issue DIV 6/3 -> Busy and Done stay 0, and Hi/Lo stay unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU are ignored and DivZero is tied low.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] Rdata1,
   input  logic [WIDTH-1:0] Rdata2,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd3;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULDIV_DIV_EN
   localparam logic [1:0] S_DIV    = 2'd2;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial hi / remainder, multiplier / quotient}
   logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
   logic               sign_q, sign_d;   // product / quotient negative
   logic               rsign_q, rsign_d; // remainder negative
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d, dz_q, dz_d;

   logic             signed_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   // Signed ops have Op[0] == 0; magnitudes are what the iteration consumes.
   assign signed_op = ~Op[0];
   assign a_neg     = signed_op & Rdata1[WIDTH-1];
   assign b_neg     = signed_op & Rdata2[WIDTH-1];
   assign a_mag     = a_neg ? -Rdata1 : Rdata1;
   assign b_mag     = b_neg ? -Rdata2 : Rdata2;

   logic [WIDTH:0] mul_sum;
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

`ifdef MULDIV_DIV_EN
   logic [WIDTH:0] div_shift, div_diff;
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opb_q};
`endif

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;
   assign prod_fix = sign_q  ? -acc_q : acc_q;
   assign quot_fix = sign_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      sign_d   = sign_q;
      rsign_d  = rsign_q;
      is_div_d = is_div_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               case (Op)
                  OP_MULT, OP_MULTU: begin
                     state_d  = S_MUL;
                     cnt_d    = '0;
                     acc_d    = {{WIDTH{1'b0}}, b_mag};
                     opb_d    = a_mag;
                     sign_d   = a_neg ^ b_neg;
                     rsign_d  = 1'b0;
                     is_div_d = 1'b0;
                  end
`ifdef MULDIV_DIV_EN
                  OP_DIV, OP_DIVU: begin
                     if (Rdata2 == '0) begin
                        hi_d   = Rdata1;
                        lo_d   = '1;
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                     end else begin
                        state_d  = S_DIV;
                        cnt_d    = '0;
                        acc_d    = {{WIDTH{1'b0}}, a_mag};
                        opb_d    = b_mag;
                        sign_d   = a_neg ^ b_neg;
                        rsign_d  = a_neg;
                        is_div_d = 1'b1;
                     end
                  end
`endif
                  OP_MTHI: hi_d = Rdata1;
                  OP_MTLO: lo_d = Rdata1;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
         end
`ifdef MULDIV_DIV_EN
         S_DIV: begin
            // Restoring step: keep the trial difference only when it does not go negative.
            if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
         end
`endif
         S_FIX: begin
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         sign_q   <= 1'b0;
         rsign_q  <= 1'b0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         sign_q   <= sign_d;
         rsign_q  <= rsign_d;
         is_div_q <= is_div_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   assign Busy    = (state_q != S_IDLE);
   assign Done    = done_q;
   assign DivZero = dz_q;
   assign Hi      = hi_q;
   assign Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32); divide vectors are selected by MULDIV_DIV_EN.
module tb_muldiv_unit;
   localparam int W = 32;

   logic          CLK, RST, Start;
   logic [2:0]    Op;
   logic [W-1:0]  Rdata1, Rdata2;
   logic          Busy, Done, DivZero;
   logic [W-1:0]  Hi, Lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .Rdata1(Rdata1), .Rdata2(Rdata2),
      .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Results of the last run_op window
   int           n_busy, n_done, n_dz, done_idx;
   logic         dz_at_done;
   logic [W-1:0] hi_before, lo_before, hi_pre, lo_pre, hi_at_done, lo_at_done;

   localparam logic [W-1:0] CHAIN_VAL = 32'hA5A5A5A5;

   // Issue one request from a sample point, then observe 60 cycles after the accept edge.
   // Sample i is taken 1 time unit after the i-th edge following the accept edge.
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke, input bit chain);
      n_busy = 0; n_done = 0; n_dz = 0; done_idx = -1; dz_at_done = 1'b0;
      hi_before = Hi; lo_before = Lo; hi_pre = '0; lo_pre = '0;
      hi_at_done = '0; lo_at_done = '0;
      Start = 1'b1; Op = op; Rdata1 = a; Rdata2 = b;
      @(posedge CLK); #1;
      Start = 1'b0;
      Rdata1 = ~a; Rdata2 = ~b;
      for (int i = 0; i < 60; i++) begin
         if (Busy) n_busy++;
         if (DivZero) n_dz++;
         if (i == W) begin hi_pre = Hi; lo_pre = Lo; end
         if (i == 6) Start = 1'b0;
         if (poke && i == 5) begin
            Start = 1'b1; Op = 3'b100; Rdata1 = 32'hDEADBEEF;
         end
         if (Done) begin
            n_done++;
            if (done_idx < 0) begin
               done_idx = i; dz_at_done = DivZero; hi_at_done = Hi; lo_at_done = Lo;
               if (chain) begin Start = 1'b1; Op = 3'b101; Rdata1 = CHAIN_VAL; end
            end
         end else if (chain && done_idx >= 0) begin
            Start = 1'b0;
         end
         @(posedge CLK); #1;
      end
      Start = 1'b0;
   endtask

   task automatic check_iter(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      check({tag, " hi"},    hi_at_done, exp_hi);
      check({tag, " lo"},    lo_at_done, exp_lo);
      check({tag, " busy"},  n_busy, W + 1);
      check({tag, " done"},  n_done, 1);
      check({tag, " lat"},   done_idx, W + 1);
      check({tag, " hold"},  {hi_pre, lo_pre}, {hi_before, lo_before});
   endtask

   int ab_done;

   initial begin
      RST = 1'b1; Start = 1'b1; Op = 3'b000; Rdata1 = 32'd9; Rdata2 = 32'd9;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0; Start = 1'b0;
      check("rst busy", Busy, 1'b0);
      check("rst done", Done, 1'b0);
      check("rst dz",   DivZero, 1'b0);
      check("rst hi",   Hi, '0);
      check("rst lo",   Lo, '0);

      run_op(3'b100, 32'h12345678, 32'h0, 0, 0);
      check("mthi hi",   Hi, 32'h12345678);
      check("mthi lo",   Lo, 32'h0);
      check("mthi busy", n_busy, 0);
      check("mthi done", n_done, 0);

      run_op(3'b000, 32'hFFFFFFFE, 32'h00000003, 0, 0);
      check_iter("mult -2*3", 32'hFFFFFFFF, 32'hFFFFFFFA);

      run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
      check_iter("multu max", 32'hFFFFFFFE, 32'h00000001);

      run_op(3'b000, 32'hFFFFFFFB, 32'hFFFFFFF9, 0, 1);
      check_iter("mult -5*-7", 32'h0, 32'h23);
      check("b2b mtlo lo", Lo, CHAIN_VAL);
      check("b2b mtlo hi", Hi, 32'h0);

      run_op(3'b001, 32'd3, 32'd4, 1, 0);
      check_iter("multu busy-start", 32'h0, 32'd12);
      check("busy-start hi", Hi, 32'h0);

      run_op(3'b000, 32'h80000000, 32'h80000000, 0, 0);
      check_iter("mult min*min", 32'h40000000, 32'h0);

      run_op(3'b101, 32'h0F0F0F0F, 32'h0, 0, 0);
      check("mtlo lo", Lo, 32'h0F0F0F0F);
      check("mtlo hi", Hi, 32'h40000000);

      run_op(3'b111, 32'h11111111, 32'h22222222, 0, 0);
      check("rsvd busy", n_busy, 0);
      check("rsvd done", n_done, 0);
      check("rsvd hilo", {Hi, Lo}, {32'h40000000, 32'h0F0F0F0F});

`ifdef MULDIV_DIV_EN
      run_op(3'b010, 32'hFFFFFFF9, 32'd2, 0, 0);
      check_iter("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD);
      check("div -7/2 dz", n_dz, 0);

      run_op(3'b011, 32'h80000000, 32'hFFFFFFFF, 0, 0);
      check_iter("divu min/max", 32'h80000000, 32'h0);

      run_op(3'b011, 32'd5, 32'd0, 0, 0);
      check("divz hi",     hi_at_done, 32'd5);
      check("divz lo",     lo_at_done, 32'hFFFFFFFF);
      check("divz lat",    done_idx, 0);
      check("divz done",   n_done, 1);
      check("divz dz",     n_dz, 1);
      check("divz dz@dn",  dz_at_done, 1'b1);
      check("divz busy",   n_busy, 0);

      run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 0, 0);
      check_iter("div min/-1", 32'h0, 32'h80000000);
      check("div min/-1 dz", n_dz, 0);

      run_op(3'b010, 32'd7, 32'hFFFFFFFE, 0, 0);
      check_iter("div 7/-2", 32'd1, 32'hFFFFFFFD);

      run_op(3'b011, 32'd100, 32'd7, 0, 0);
      check_iter("divu 100/7", 32'd2, 32'd14);
`else
      run_op(3'b010, 32'd6, 32'd3, 0, 0);
      check("nodiv busy", n_busy, 0);
      check("nodiv done", n_done, 0);
      check("nodiv hilo", {Hi, Lo}, {hi_before, lo_before});

      run_op(3'b011, 32'd5, 32'd0, 0, 0);
      check("nodiv divz dz",   n_dz, 0);
      check("nodiv divz done", n_done, 0);
      check("nodiv divz hilo", {Hi, Lo}, {hi_before, lo_before});
`endif

      // Reset aborting an in-flight multiply; count from the first sample after reset release.
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      ab_done = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (Done) ab_done++;
         if (cyc == 19) begin
            check("abort busy mid",  Busy, 1'b1);
            check("abort hi mid",    Hi, 32'h12345678);
            check("abort lo mid",    Lo, 32'h0);
         end
         if (cyc == 21) begin
            check("abort hi",   Hi, 32'h0);
            check("abort lo",   Lo, 32'h0);
            check("abort busy", Busy, 1'b0);
         end
         case (cyc)
            2:  begin Start = 1'b1; Op = 3'b100; Rdata1 = 32'h12345678; end
            3:  Start = 1'b0;
            10: begin Start = 1'b1; Op = 3'b000; Rdata1 = 32'hFFFFFFFE; Rdata2 = 32'd3; end
            11: Start = 1'b0;
            15: begin Start = 1'b1; Op = 3'b101; Rdata1 = 32'h55; end
            16: Start = 1'b0;
            20: RST = 1'b1;
            21: RST = 1'b0;
            default: ;
         endcase
         @(posedge CLK); #1;
      end
      check("abort no done", ab_done, 0);
      check("abort idle",    Busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
